// File: rtl/cache_fill_responder.sv
// Line-fill responder: bursts an 8-word line from memory, then replays it critical-word-first.
// Optional LINE_REUSE_EN keeps the last streamed line for refills that need no memory burst.
module cache_fill_responder #(
   parameter int ADDR_BITS = 26,
   parameter int DATA_BITS = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   fill_req,
   input  logic [31:0]            fill_addr,
   output logic                   fill_strobe,
   output logic [DATA_BITS-1:0]   fill_data,
   output logic                   busy,
   input  logic                   inval,
   output logic                   mem_req,
   output logic [ADDR_BITS-5:0]   mem_addr,
   input  logic                   mem_ack,
   input  logic                   mem_valid,
   input  logic [DATA_BITS-1:0]   mem_data
);

   typedef enum logic [1:0] {IDLE, REQ, COLLECT, STREAM} state_t;

   state_t               state_q;
   logic [2:0]           crit_q;
   logic [2:0]           cnt_q;
   logic [DATA_BITS-1:0] line_q [8];
   logic                 capture;
   logic                 last_word;
   logic                 reuse_hit;
   logic [2:0]           rd_idx;
   logic [DATA_BITS-1:0] rd_word;

   wire unused_ok = ^{inval, fill_addr[31:ADDR_BITS], fill_addr[0]};

   assign capture   = mem_valid && (state_q == REQ || state_q == COLLECT);
   assign last_word = capture && (cnt_q == 3'd7);

   // The critical word is emitted on the edge that captures word 7, so it may need the bypass.
   always_comb begin
      rd_idx  = (state_q == STREAM) ? crit_q + cnt_q : crit_q;
      rd_word = line_q[rd_idx];
      if (last_word && crit_q == 3'd7) begin
         rd_word = mem_data;
      end
   end

   always_ff @(posedge clk) begin
      if (capture) begin
         line_q[cnt_q] <= mem_data;
      end
   end

`ifdef LINE_REUSE_EN
   logic                 reuse_vld_q;
   logic                 inval_seen_q;
   logic [ADDR_BITS-5:0] reuse_line_q;

   assign reuse_hit = reuse_vld_q && !inval && (fill_addr[ADDR_BITS-1:4] == reuse_line_q);

   // An invalidate seen at any point of a fill keeps that fill from becoming reusable.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         reuse_vld_q  <= 1'b0;
         inval_seen_q <= 1'b0;
         reuse_line_q <= '0;
      end else begin
         if (inval) begin
            reuse_vld_q <= 1'b0;
         end
         if (state_q == IDLE && fill_req) begin
            inval_seen_q <= inval;
         end else if (inval) begin
            inval_seen_q <= 1'b1;
         end
         if (state_q == STREAM && cnt_q == 3'd7) begin
            reuse_line_q <= mem_addr;
            if (!inval && !inval_seen_q) begin
               reuse_vld_q <= 1'b1;
            end
         end
      end
   end
`else
   assign reuse_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         crit_q      <= '0;
         cnt_q       <= '0;
         fill_strobe <= 1'b0;
         fill_data   <= '0;
         busy        <= 1'b0;
         mem_req     <= 1'b0;
         mem_addr    <= '0;
      end else begin
         fill_strobe <= 1'b0;
         if (capture) begin
            cnt_q <= cnt_q + 3'd1;
         end
         case (state_q)
            IDLE: begin
               if (fill_req) begin
                  crit_q   <= fill_addr[3:1];
                  mem_addr <= fill_addr[ADDR_BITS-1:4];
                  cnt_q    <= '0;
                  busy     <= 1'b1;
                  if (reuse_hit) begin
                     state_q <= STREAM;
                  end else begin
                     mem_req <= 1'b1;
                     state_q <= REQ;
                  end
               end
            end
            REQ: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  state_q <= COLLECT;
               end
            end
            COLLECT: begin
            end
            STREAM: begin
               fill_data   <= rd_word;
               fill_strobe <= (cnt_q == 3'd0);
               cnt_q       <= cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  state_q <= IDLE;
                  busy    <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
         if (last_word) begin
            fill_data   <= rd_word;
            fill_strobe <= 1'b1;
            cnt_q       <= 3'd1;
            mem_req     <= 1'b0;
            state_q     <= STREAM;
         end
      end
   end

endmodule

// File: tb/tb_cache_fill_responder.sv
// Randomized bench for cache_fill_responder against a line-level reference model.
// Reuse expectations follow LINE_REUSE_EN at compile time.
module tb_cache_fill_responder;

   localparam int ADDR_BITS = 26;
   localparam int DATA_BITS = 16;
`ifdef LINE_REUSE_EN
   localparam bit REUSE = 1'b1;
`else
   localparam bit REUSE = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 reset_n = 1'b0;
   logic                 fill_req = 1'b0;
   logic [31:0]          fill_addr = '0;
   logic                 fill_strobe;
   logic [DATA_BITS-1:0] fill_data;
   logic                 busy;
   logic                 inval = 1'b0;
   logic                 mem_req;
   logic [ADDR_BITS-5:0] mem_addr;
   logic                 mem_ack = 1'b0;
   logic                 mem_valid = 1'b0;
   logic [DATA_BITS-1:0] mem_data = '0;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: memory contents for the next burst, last streamed line, reuse state.
   logic [15:0]          mem_img   [8];
   logic [15:0]          last_data [8];
   bit                   rv_vld  = 1'b0;
   logic [ADDR_BITS-5:0] rv_line = '0;

   cache_fill_responder #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)) dut (
      .clk(clk), .reset_n(reset_n), .fill_req(fill_req), .fill_addr(fill_addr),
      .fill_strobe(fill_strobe), .fill_data(fill_data), .busy(busy), .inval(inval),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_valid(mem_valid), .mem_data(mem_data)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_img_seq(input logic [15:0] base);
      for (int i = 0; i < 8; i++) mem_img[i] = base + 16'(i);
   endtask

   task automatic set_img_rand();
      for (int i = 0; i < 8; i++) mem_img[i] = 16'($urandom);
   endtask

   // One complete fill; acts as the memory port and checks the replay to the cache.
   task automatic do_fill(input logic [31:0] addr, input int ack_dly, input int gap,
                          input bit extra, input bit hold);
      logic [15:0] exp_w [8];
      bit   hit, acked, saw, done;
      int   crit, k, strobe_at, w, gcnt, dly;
      hit  = REUSE && rv_vld && (addr[ADDR_BITS-1:4] == rv_line);
      crit = int'(addr[3:1]);
      for (int i = 0; i < 8; i++) exp_w[i] = hit ? last_data[(crit + i) % 8] : mem_img[(crit + i) % 8];
      fill_req  = 1'b1;
      fill_addr = addr;
      @(posedge clk); #1;
      strobe_at = hit ? 1 : -1;
      k = 0; w = 0; gcnt = 0; dly = ack_dly;
      acked = 1'b0; saw = 1'b0; done = 1'b0;
      for (int c = 0; c < 600 && !done; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         if (mem_req) saw = 1'b1;
         if (c == 0) begin
            chk("mreq_latency", 32'(mem_req), 32'(!hit));
            if (!hit) chk("mem_addr", 32'(mem_addr), 32'(addr[ADDR_BITS-1:4]));
         end
         if (k == 0) begin
            if (fill_strobe) begin
               chk("strobe_latency", c, strobe_at);
               chk("word0", 32'(fill_data), 32'(exp_w[0]));
               chk("busy_stream", 32'(busy), 32'd1);
               k = 1;
            end
         end else if (k < 8) begin
            chk($sformatf("word%0d", k), {15'd0, fill_strobe, fill_data}, {16'd0, exp_w[k]});
            k++;
         end else begin
            chk("busy_end", 32'(busy), 32'd0);
            done = 1'b1;
         end
         if (!hold || k >= 1) fill_req = 1'b0;
         mem_ack   = 1'b0;
         mem_valid = 1'b0;
         if (mem_req && !acked) begin
            if (dly == 0) begin
               mem_ack = 1'b1;
               acked   = 1'b1;
            end else dly--;
         end
         if (acked && w < (extra ? 9 : 8)) begin
            if (gcnt == 0) begin
               mem_valid = 1'b1;
               mem_data  = (w < 8) ? mem_img[w] : 16'hDEAD;
               w++;
               gcnt = gap - 1;
               if (w == 8) strobe_at = c + 1;
            end else gcnt--;
         end
      end
      mem_ack   = 1'b0;
      mem_valid = 1'b0;
      fill_req  = 1'b0;
      chk("fill_done", 32'(done), 32'd1);
      chk("mreq_seen", 32'(saw), 32'(!hit));
      if (!hit) for (int i = 0; i < 8; i++) last_data[i] = mem_img[i];
      rv_vld  = 1'b1;
      rv_line = addr[ADDR_BITS-1:4];
   endtask

   task automatic idle_noise();
      for (int i = 0; i < 3; i++) begin
         mem_valid = 1'b1;
         mem_data  = 16'($urandom);
         @(posedge clk); #1;
      end
      mem_valid = 1'b0;
   endtask

   task automatic pulse_inval();
      inval = 1'b1;
      @(posedge clk); #1;
      inval  = 1'b0;
      rv_vld = 1'b0;
   endtask

   task automatic reset_mid_collect();
      set_img_rand();
      fill_req  = 1'b1;
      fill_addr = 32'h0000_5678;
      @(posedge clk); #1;
      fill_req = 1'b0;
      chk("rst_mreq_pre", 32'(mem_req), 32'd1);
      for (int i = 0; i < 4; i++) begin
         mem_ack   = (i == 0);
         mem_valid = 1'b1;
         mem_data  = mem_img[i];
         @(posedge clk); #1;
      end
      mem_ack   = 1'b0;
      mem_valid = 1'b0;
      chk("rst_busy_pre", 32'(busy), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rst_mreq", 32'(mem_req), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_strobe", 32'(fill_strobe), 32'd0);
      @(posedge clk); #3;
      reset_n = 1'b1;
      rv_vld  = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] addr;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_strobe", 32'(fill_strobe), 32'd0);
      chk("reset_data", 32'(fill_data), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_mreq", 32'(mem_req), 32'd0);
      chk("reset_maddr", 32'(mem_addr), 32'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      set_img_seq(16'hA000);
      do_fill(32'h0000_1234, 0, 1, 1'b0, 1'b1);
      set_img_seq(16'hB000);
      do_fill(32'h0000_001E, 0, 1, 1'b0, 1'b1);
      set_img_rand();
      do_fill(32'h0003_4562, 20, 3, 1'b1, 1'b0);
      idle_noise();
      set_img_rand();
      do_fill(32'h0000_0ABC, 2, 2, 1'b0, 1'b1);

      reset_mid_collect();
      set_img_seq(16'hA000);
      do_fill(32'h0000_1234, 1, 1, 1'b0, 1'b1);
      set_img_seq(16'hC000);
      do_fill(32'h0000_1234, 0, 1, 1'b0, 1'b1);
      pulse_inval();
      do_fill(32'h0000_1234, 0, 1, 1'b0, 1'b1);

      for (int r = 0; r < 10; r++) begin
         addr = ($urandom_range(0, 1) == 1) ? 32'h0000_1230 : $urandom;
         addr[3:1] = 3'($urandom_range(0, 7));
         set_img_rand();
         if ($urandom_range(0, 3) == 0) pulse_inval();
         if ($urandom_range(0, 3) == 0) idle_noise();
         do_fill(addr, $urandom_range(0, 5), $urandom_range(1, 3),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
